fwd_hazard_unit: RTL and testbench

Parametrised operand-forwarding and hazard-detection unit for the pipelined RISC-V core, sitting beside the EX stage. It replaces fixed two-stage forwarding with N source operands and M forwarding stages, and never forwards x0. It adds stage-level data-ready qualification for load-use stalls and a register scoreboard for variable-latency units such as mul/div. It drives per-operand mux selects, a pipeline stall, and a saturating stall-cycle counter.

---
 rtl/fwd_pkg.sv | 15 +
 rtl/fwd_scoreboard.sv | 41 ++++
 rtl/fwd_hazard_unit.sv | 85 ++++++++
 tb/tb_fwd_hazard_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-forwarding / hazard unit.
// Select code 0 always means "take the operand from the register file".
package fwd_pkg;

   localparam int REG_ADDR_W_DEF = 5;
   localparam int FWD_SEL_RF     = 0;

   typedef logic [REG_ADDR_W_DEF-1:0] reg_addr_t;

   // Forwarding stage k is reached through mux input k+1.
   function automatic int fwd_sel_code(input int stage);
      return stage + 1;
   endfunction

endpackage

// File: rtl/fwd_scoreboard.sv
// Busy bit per architectural register for variable-latency results.
// A set and a clear of the same register in one cycle leaves it busy.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       set_en,
   input  logic [REG_ADDR_W-1:0]      set_rd,
   input  logic                       clr_en,
   input  logic [REG_ADDR_W-1:0]      clr_rd,
   output logic [2**REG_ADDR_W-1:0]   busy
);

   logic [2**REG_ADDR_W-1:0] busy_d, busy_q;

   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_rd] = 1'b0;
      end
      // Applied after the clear: a newer producer for the same register is still pending.
      if (set_en && (set_rd != '0)) begin
         busy_d[set_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use / scoreboard stall and a saturating
// stall-cycle counter for the EX stage.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int NUM_SRC    = 2,
   parameter int NUM_FWD    = 2,
   parameter int SEL_W      = $clog2(NUM_FWD + 1),
   parameter int CNT_W      = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]   ex_rs,
   input  logic [NUM_SRC-1:0]                   ex_rs_used,
   input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0]   fwd_rd,
   input  logic [NUM_FWD-1:0]                   fwd_wren,
   input  logic [NUM_FWD-1:0]                   fwd_ready,
   input  logic                                 lat_issue,
   input  logic [REG_ADDR_W-1:0]                lat_issue_rd,
   input  logic                                 lat_done,
   input  logic [REG_ADDR_W-1:0]                lat_done_rd,
   output logic [NUM_SRC-1:0][SEL_W-1:0]        rs_sel,
   output logic                                 stall,
   output logic [CNT_W-1:0]                     stall_cnt
);

   logic [2**REG_ADDR_W-1:0] busy;
   logic [NUM_SRC-1:0]       sel_rdy;
   logic [NUM_SRC-1:0]       load_haz;
   logic [NUM_SRC-1:0]       sb_haz;
   logic [CNT_W-1:0]         stall_cnt_d, stall_cnt_q;

   always_comb begin
      rs_sel   = '0;
      sel_rdy  = '1;
      load_haz = '0;
      sb_haz   = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (ex_rs_used[s] && (ex_rs[s] != '0)) begin
            // Walk oldest to youngest so the youngest matching producer overrides.
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
               if (fwd_wren[k] && (fwd_rd[k] == ex_rs[s])) begin
                  rs_sel[s]  = SEL_W'(fwd_sel_code(k));
                  sel_rdy[s] = fwd_ready[k];
               end
            end
            load_haz[s] = (rs_sel[s] != SEL_W'(FWD_SEL_RF)) && !sel_rdy[s];
            sb_haz[s]   = busy[ex_rs[s]];
         end
      end
   end

   assign stall = !rst && ((|load_haz) || (|sb_haz));

   fwd_scoreboard #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_scoreboard (
      .clk    (clk),
      .rst    (rst),
      .set_en (lat_issue && !stall),
      .set_rd (lat_issue_rd),
      .clr_en (lat_done),
      .clr_rd (lat_done_rd),
      .busy   (busy)
   );

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with a behavioural reference model
// checked every cycle plus hand-computed expectations.
module tb_fwd_hazard_unit;
   import fwd_pkg::*;

   localparam int RW      = 5;
   localparam int NS      = 2;
   localparam int NF      = 2;
   localparam int SW      = $clog2(NF + 1);
   localparam int CW      = 8;

   logic                       clk;
   logic                       rst;
   logic [NS-1:0][RW-1:0]      ex_rs;
   logic [NS-1:0]              ex_rs_used;
   logic [NF-1:0][RW-1:0]      fwd_rd;
   logic [NF-1:0]              fwd_wren;
   logic [NF-1:0]              fwd_ready;
   logic                       lat_issue;
   logic [RW-1:0]              lat_issue_rd;
   logic                       lat_done;
   logic [RW-1:0]              lat_done_rd;
   logic [NS-1:0][SW-1:0]      rs_sel;
   logic                       stall;
   logic [CW-1:0]              stall_cnt;

   int checks;
   int errors;

   fwd_hazard_unit #(
      .REG_ADDR_W (RW),
      .NUM_SRC    (NS),
      .NUM_FWD    (NF),
      .CNT_W      (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_rs        (ex_rs),
      .ex_rs_used   (ex_rs_used),
      .fwd_rd       (fwd_rd),
      .fwd_wren     (fwd_wren),
      .fwd_ready    (fwd_ready),
      .lat_issue    (lat_issue),
      .lat_issue_rd (lat_issue_rd),
      .lat_done     (lat_done),
      .lat_done_rd  (lat_done_rd),
      .rs_sel       (rs_sel),
      .stall        (stall),
      .stall_cnt    (stall_cnt)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model
   bit            m_busy [32];
   logic [CW-1:0] m_cnt;
   logic [CW-1:0] exp_q [$];

   function automatic int m_sel(input int s);
      if (!ex_rs_used[s] || ex_rs[s] == 0) return 0;
      for (int k = 0; k < NF; k++) begin
         if (fwd_wren[k] && fwd_rd[k] == ex_rs[s]) return k + 1;
      end
      return 0;
   endfunction

   function automatic bit m_stall();
      for (int s = 0; s < NS; s++) begin
         if (ex_rs_used[s] && ex_rs[s] != 0) begin
            int p;
            p = m_sel(s);
            if (p != 0 && !fwd_ready[p-1]) return 1'b1;
            if (m_busy[ex_rs[s]]) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         m_cnt = '0;
         exp_q.delete();
      end else begin
         bit st;
         st = m_stall();
         if (lat_done) m_busy[lat_done_rd] = 1'b0;
         if (lat_issue && !st && lat_issue_rd != 0) m_busy[lat_issue_rd] = 1'b1;
         if (st && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
         exp_q.push_back(m_cnt);
      end
   end

   // Compare process
   always @(negedge clk) begin
      for (int s = 0; s < NS; s++) chk("model_rs_sel", int'(rs_sel[s]), m_sel(s));
      chk("model_stall", int'(stall), rst ? 0 : int'(m_stall()));
      if (rst) begin
         chk("model_cnt_rst", int'(stall_cnt), 0);
      end else if (exp_q.size() > 0) begin
         logic [CW-1:0] e;
         e = exp_q.pop_front();
         chk("model_stall_cnt", int'(stall_cnt), int'(e));
      end
   end

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ex_rs        = '0;
      ex_rs_used   = '0;
      fwd_rd       = '0;
      fwd_wren     = '0;
      fwd_ready    = '1;
      lat_issue    = 1'b0;
      lat_issue_rd = '0;
      lat_done     = 1'b0;
      lat_done_rd  = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      clear_inputs();
      step();
      step();
      chk("reset_stall", int'(stall), 0);
      chk("reset_cnt", int'(stall_cnt), 0);
      chk("reset_sel0", int'(rs_sel[0]), 0);
      rst = 1'b0;

      // Youngest producer wins
      fwd_rd[0] = 5; fwd_rd[1] = 5; fwd_wren = 2'b11; fwd_ready = 2'b11;
      ex_rs[0] = 5; ex_rs_used = 2'b01;
      #2;
      chk("youngest_sel", int'(rs_sel[0]), 1);
      chk("youngest_stall", int'(stall), 0);
      step();

      // x0 never forwarded
      fwd_rd[0] = 0; ex_rs[0] = 0;
      #2;
      chk("x0_sel", int'(rs_sel[0]), 0);
      chk("x0_stall", int'(stall), 0);
      step();

      // Load-use: one stall, then forward from the older stage
      clear_inputs();
      fwd_rd[0] = 7; fwd_wren = 2'b01; fwd_ready = 2'b10;
      ex_rs[1] = 7; ex_rs_used = 2'b10;
      #2;
      chk("load_stall", int'(stall), 1);
      chk("load_sel", int'(rs_sel[1]), 1);
      step();
      chk("load_cnt", int'(stall_cnt), 1);
      fwd_rd[1] = 7; fwd_wren = 2'b10; fwd_ready = 2'b11;
      #2;
      chk("load_fwd_sel", int'(rs_sel[1]), 2);
      chk("load_fwd_stall", int'(stall), 0);
      step();

      // Scoreboard: issue rd=9, consumer stalls through the completion cycle
      clear_inputs();
      lat_issue = 1'b1; lat_issue_rd = 9;
      step();
      lat_issue = 1'b0;
      ex_rs[0] = 9; ex_rs_used = 2'b01;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) begin
            lat_done = 1'b1; lat_done_rd = 9;
         end
         #2;
         chk("sb_stall", int'(stall), 1);
         step();
      end
      lat_done = 1'b0;
      #2;
      chk("sb_release", int'(stall), 0);
      chk("sb_cnt", int'(stall_cnt), 5);
      step();

      // Same-cycle set and clear keeps the register busy
      clear_inputs();
      lat_issue = 1'b1; lat_issue_rd = 3;
      step();
      lat_done = 1'b1; lat_done_rd = 3;
      step();
      lat_issue = 1'b0;
      ex_rs[0] = 3; ex_rs_used = 2'b01;
      #2;
      chk("setclr_busy", int'(stall), 1);
      step();
      lat_done = 1'b0;
      #2;
      chk("setclr_cleared", int'(stall), 0);
      step();

      // Issue during a stall is ignored
      clear_inputs();
      fwd_rd[0] = 4; fwd_wren = 2'b01; fwd_ready = 2'b10;
      ex_rs[0] = 4; ex_rs_used = 2'b01;
      lat_issue = 1'b1; lat_issue_rd = 10;
      step();
      clear_inputs();
      ex_rs[0] = 10; ex_rs_used = 2'b01;
      #2;
      chk("issue_ignored", int'(stall), 0);
      chk("issue_ignored_cnt", int'(stall_cnt), 7);
      step();

      // Async reset clears scoreboard and counter without a clock edge
      clear_inputs();
      lat_issue = 1'b1; lat_issue_rd = 12;
      step();
      lat_issue = 1'b0;
      ex_rs[0] = 12; ex_rs_used = 2'b01;
      #2;
      chk("busy12_stall", int'(stall), 1);
      repeat (93) step();
      chk("cnt_100", int'(stall_cnt), 100);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_cnt", int'(stall_cnt), 0);
      chk("async_rst_stall", int'(stall), 0);
      step();
      rst = 1'b0;
      #2;
      chk("rst_busy_dropped", int'(stall), 0);
      step();

      // Saturation
      clear_inputs();
      fwd_rd[0] = 4; fwd_wren = 2'b01; fwd_ready = 2'b10;
      ex_rs[0] = 4; ex_rs_used = 2'b01;
      repeat (254) step();
      chk("cnt_max_m1", int'(stall_cnt), 254);
      repeat (3) step();
      chk("cnt_saturate", int'(stall_cnt), 255);
      clear_inputs();
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
